vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_edge_sync.sv | 29 ++
 rtl/vga_timing.sv | 129 ++++++++++++
 tb/tb_vga_timing.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480 timing, derived totals and sync
// windows, the counter type and a small window-compare helper.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  typedef logic [CNT_W-1:0] count_t;

  // True when v lies in the inclusive window [lo, hi].
  function automatic logic in_window(input count_t v, input count_t lo, input count_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_edge_sync.sv
// Two-flop synchronizer for a slow asynchronous input followed by a
// rising-edge detector; rise is high for one clk per synchronized 0->1 edge.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Bring d into the clk domain and keep one cycle of history for the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters advanced by pix_en,
// zero-latency sync/blanking flags, a frame-start pulse and a game tick that
// releases a slow asynchronous game clock edge at the start of vertical blanking.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             game_clk,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start,
  output logic             game_tick,
  output logic             tick_overrun
);

  localparam int LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam count_t H_LAST   = count_t'(LINE_LEN - 1);
  localparam count_t V_LAST   = count_t'(FRAME_LEN - 1);
  localparam count_t H_ACT    = count_t'(H_ACTIVE);
  localparam count_t V_ACT    = count_t'(V_ACTIVE);
  localparam count_t HS_START = count_t'(H_ACTIVE + H_FP);
  localparam count_t HS_END   = count_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam count_t VS_START = count_t'(V_ACTIVE + V_FP);
  localparam count_t VS_END   = count_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  count_t x_q, x_d;
  count_t y_q, y_d;
  logic   hsync_q;
  logic   vsync_q;
  logic   video_q;
  logic   frame_q;
  logic   tick_q;
  logic   overrun_q;
  logic   pending_q;
  logic   gameRise;
  logic   blankStart;
  logic   tickRelease;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (game_clk),
    .rise (gameRise)
  );

  // Next raster position; only moves on a pixel-enable cycle.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  assign blankStart  = pix_en && (x_d == '0) && (y_d == V_ACT);
  assign tickRelease = pending_q && blankStart;

  // Counters and the flags derived from the next position, so they line up with x/y.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (pix_en) begin
        x_q     <= x_d;
        y_q     <= y_d;
        hsync_q <= ~in_window(x_d, HS_START, HS_END);
        vsync_q <= ~in_window(y_d, VS_START, VS_END);
        video_q <= (x_d < H_ACT) && (y_d < V_ACT);
        frame_q <= (x_d == '0) && (y_d == '0);
      end
    end
  end

  // Hold one game edge until blanking starts; a new edge on the release clk re-arms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tick_q <= tickRelease;
      if (gameRise) begin
        pending_q <= 1'b1;
      end else if (tickRelease) begin
        pending_q <= 1'b0;
      end
      if (gameRise && pending_q && !tickRelease) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_on     = video_q;
  assign frame_start  = frame_q;
  assign game_tick    = tick_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: a full-size instance for the line timing and a
// reduced-timing instance for whole-frame and game-tick behaviour.
module tb_vga_timing;

  localparam int A_HTOT = 800, A_VTOT = 525, A_HACT = 640, A_VACT = 480;
  localparam int A_HSS = 656, A_HSE = 751, A_VSS = 490, A_VSE = 491;
  localparam int B_HTOT = 15, B_VTOT = 13, B_HACT = 8, B_VACT = 6;
  localparam int B_HSS = 10, B_HSE = 12, B_VSS = 8, B_VSE = 9;

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit vid;
    bit fs;
  } exp_t;

  typedef struct {
    int pulses;
    int x;
    int y;
    bit hs;
    bit vid;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, pixA, gameA;
  logic [9:0] xA, yA;
  logic       hsyncA, vsyncA, videoA, frameA, tickA, ovrA;
  logic       rstB, pixB, gameB;
  logic [9:0] xB, yB;
  logic       hsyncB, vsyncB, videoB, frameB, tickB, ovrB;

  vga_timing dutA (
    .clk(clk), .rst(rstA), .pix_en(pixA), .game_clk(gameA),
    .x(xA), .y(yA), .hsync(hsyncA), .vsync(vsyncA), .video_on(videoA),
    .frame_start(frameA), .game_tick(tickA), .tick_overrun(ovrA)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dutB (
    .clk(clk), .rst(rstB), .pix_en(pixB), .game_clk(gameB),
    .x(xB), .y(yB), .hsync(hsyncB), .vsync(vsyncB), .video_on(videoB),
    .frame_start(frameB), .game_tick(tickB), .tick_overrun(ovrB)
  );

  int compared = 0;
  int mismatched = 0;
  exp_t sbA[$];
  exp_t sbB[$];
  int axm = 0, aym = 0, bxm = 0, bym = 0;
  int hsLowA = 0, vsLowB = 0, fsCountB = 0;
  int ticksB = 0, tickX = -1, tickY = -1;

  // One comparison: counted, and reported when it disagrees.
  task automatic checkOutput(input string name, input int act, input int want);
    compared++;
    if (act != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t mkExp(input int px, input int py, input bit fs,
                                 input int hAct, input int hss, input int hse,
                                 input int vAct, input int vss, input int vse);
    exp_t e;
    e.x   = px;
    e.y   = py;
    e.hs  = !(px >= hss && px <= hse);
    e.vs  = !(py >= vss && py <= vse);
    e.vid = (px < hAct) && (py < vAct);
    e.fs  = fs;
    return e;
  endfunction

  // Drive one clk of stimulus on instance 0 (A) or 1 (B), queue the expected
  // result, then compare it once the DUT has taken the edge.
  task automatic applyStimulus(input int inst, input bit pe);
    exp_t e;
    @(negedge clk);
    if (inst == 0) begin
      pixA = pe;
      if (pe) begin
        axm = (axm + 1) % A_HTOT;
        if (axm == 0) aym = (aym + 1) % A_VTOT;
      end
      sbA.push_back(mkExp(axm, aym, pe && axm == 0 && aym == 0,
                          A_HACT, A_HSS, A_HSE, A_VACT, A_VSS, A_VSE));
    end else begin
      pixB = pe;
      if (pe) begin
        bxm = (bxm + 1) % B_HTOT;
        if (bxm == 0) bym = (bym + 1) % B_VTOT;
      end
      sbB.push_back(mkExp(bxm, bym, pe && bxm == 0 && bym == 0,
                          B_HACT, B_HSS, B_HSE, B_VACT, B_VSS, B_VSE));
    end
    @(posedge clk);
    #1;
    if (inst == 0) begin
      e = sbA.pop_front();
      checkOutput("A x", int'(xA), e.x);
      checkOutput("A y", int'(yA), e.y);
      checkOutput("A hsync", int'(hsyncA), int'(e.hs));
      checkOutput("A vsync", int'(vsyncA), int'(e.vs));
      checkOutput("A video_on", int'(videoA), int'(e.vid));
      checkOutput("A frame_start", int'(frameA), int'(e.fs));
      if (pe && !hsyncA) hsLowA++;
    end else begin
      e = sbB.pop_front();
      checkOutput("B x", int'(xB), e.x);
      checkOutput("B y", int'(yB), e.y);
      checkOutput("B hsync", int'(hsyncB), int'(e.hs));
      checkOutput("B vsync", int'(vsyncB), int'(e.vs));
      checkOutput("B video_on", int'(videoB), int'(e.vid));
      checkOutput("B frame_start", int'(frameB), int'(e.fs));
      if (pe && !vsyncB) vsLowB++;
      if (frameB) fsCountB++;
      if (tickB) begin
        ticksB++;
        tickX = bxm;
        tickY = bym;
      end
    end
  endtask

  // Advance B with pix_en held high until the model sits at (tx, ty); always takes at least one step.
  task automatic runToB(input int tx, input int ty);
    int n;
    n = 0;
    do begin
      applyStimulus(1, 1'b1);
      n++;
    end while (!(bxm == tx && bym == ty) && n < 400);
    if (!(bxm == tx && bym == ty)) begin
      mismatched++;
      $display("[TB] FAIL runToB timeout: at (%0d,%0d), expected (%0d,%0d)", bxm, bym, tx, ty);
    end
  endtask

  task automatic checkResetA();
    checkOutput("A reset x", int'(xA), 0);
    checkOutput("A reset y", int'(yA), 0);
    checkOutput("A reset hsync", int'(hsyncA), 1);
    checkOutput("A reset vsync", int'(vsyncA), 1);
    checkOutput("A reset video_on", int'(videoA), 1);
    checkOutput("A reset frame_start", int'(frameA), 0);
    checkOutput("A reset game_tick", int'(tickA), 0);
    checkOutput("A reset tick_overrun", int'(ovrA), 0);
  endtask

  task automatic checkResetB();
    checkOutput("B reset x", int'(xB), 0);
    checkOutput("B reset y", int'(yB), 0);
    checkOutput("B reset hsync", int'(hsyncB), 1);
    checkOutput("B reset vsync", int'(vsyncB), 1);
    checkOutput("B reset video_on", int'(videoB), 1);
    checkOutput("B reset frame_start", int'(frameB), 0);
    checkOutput("B reset game_tick", int'(tickB), 0);
    checkOutput("B reset tick_overrun", int'(ovrB), 0);
  endtask

  initial begin
    vec_t lineVecs[8];
    int base;

    lineVecs[0] = '{639, 639, 0, 1'b1, 1'b1};
    lineVecs[1] = '{1,   640, 0, 1'b1, 1'b0};
    lineVecs[2] = '{15,  655, 0, 1'b1, 1'b0};
    lineVecs[3] = '{1,   656, 0, 1'b0, 1'b0};
    lineVecs[4] = '{95,  751, 0, 1'b0, 1'b0};
    lineVecs[5] = '{1,   752, 0, 1'b1, 1'b0};
    lineVecs[6] = '{47,  799, 0, 1'b1, 1'b0};
    lineVecs[7] = '{1,   0,   1, 1'b1, 1'b1};

    rstA = 1'b0; pixA = 1'b0; gameA = 1'b0;
    rstB = 1'b0; pixB = 1'b0; gameB = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetA();
    checkResetB();

    // Full-size line: pix_en every 4th clk, checkpoints from the table.
    @(negedge clk);
    rstA = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < lineVecs[v].pulses; k++) begin
        applyStimulus(0, 1'b1);
        repeat (3) applyStimulus(0, 1'b0);
      end
      checkOutput($sformatf("A vec%0d x", v), int'(xA), lineVecs[v].x);
      checkOutput($sformatf("A vec%0d y", v), int'(yA), lineVecs[v].y);
      checkOutput($sformatf("A vec%0d hsync", v), int'(hsyncA), int'(lineVecs[v].hs));
      checkOutput($sformatf("A vec%0d video_on", v), int'(videoA), int'(lineVecs[v].vid));
    end
    checkOutput("A hsync low pixels per line", hsLowA, 96);

    // Reduced frame: one full frame of pix_en every 4th clk.
    @(negedge clk);
    rstB = 1'b1;
    repeat (195) begin
      applyStimulus(1, 1'b1);
      repeat (3) applyStimulus(1, 1'b0);
    end
    checkOutput("B frame_start count over one frame", fsCountB, 1);
    checkOutput("B vsync low pixels per frame", vsLowB, 30);
    checkOutput("B ticks without game_clk", ticksB, 0);

    // Single game edge early in the frame: one tick at blanking start.
    base = ticksB;
    runToB(3, 2);
    gameB = 1'b1;
    runToB(0, 4);
    gameB = 1'b0;
    runToB(0, 8);
    checkOutput("single edge tick count", ticksB - base, 1);
    checkOutput("single edge tick x", tickX, 0);
    checkOutput("single edge tick y", tickY, 6);
    checkOutput("single edge overrun", int'(ovrB), 0);

    // Edge landing on the release clk re-arms for the following frame.
    base = ticksB;
    runToB(1, 1);
    gameB = 1'b1;
    runToB(1, 3);
    gameB = 1'b0;
    runToB(12, 5);
    gameB = 1'b1;
    runToB(0, 8);
    checkOutput("release-clk edge first tick", ticksB - base, 1);
    gameB = 1'b0;
    runToB(0, 8);
    checkOutput("release-clk edge tick count", ticksB - base, 2);
    checkOutput("release-clk edge tick y", tickY, 6);
    runToB(0, 8);
    checkOutput("release-clk edge no extra tick", ticksB - base, 2);
    checkOutput("release-clk edge overrun", int'(ovrB), 0);

    // Two edges in one frame merge into one tick and set overrun.
    base = ticksB;
    runToB(2, 1);
    gameB = 1'b1;
    runToB(2, 2);
    gameB = 1'b0;
    runToB(2, 4);
    gameB = 1'b1;
    runToB(2, 5);
    gameB = 1'b0;
    runToB(0, 8);
    checkOutput("merged edges tick count", ticksB - base, 1);
    checkOutput("merged edges tick x", tickX, 0);
    checkOutput("merged edges tick y", tickY, 6);
    checkOutput("merged edges overrun", int'(ovrB), 1);
    repeat (40) applyStimulus(1, 1'b0);
    runToB(0, 8);
    checkOutput("merged edges no second tick", ticksB - base, 1);
    checkOutput("overrun sticky", int'(ovrB), 1);

    // Pending edge, counters frozen, then asynchronous reset mid-frame.
    base = ticksB;
    runToB(1, 1);
    gameB = 1'b1;
    runToB(1, 2);
    gameB = 1'b0;
    runToB(4, 3);
    repeat (30) applyStimulus(1, 1'b0);
    checkOutput("frozen counters no tick", ticksB - base, 0);
    @(negedge clk);
    #2;
    rstB = 1'b0;
    #1;
    checkResetB();
    bxm = 0;
    bym = 0;
    @(negedge clk);
    @(negedge clk);
    rstB = 1'b1;
    runToB(0, 8);
    runToB(0, 8);
    checkOutput("no tick after reset", ticksB - base, 0);
    checkOutput("overrun after reset", int'(ovrB), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
